// File: rtl/fetchie_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
// Round-robin arbitration is enabled by defining ARB_RR_EN.
package fetchie_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_F = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single req/ack memory port.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed data priority.
module mem_arbiter
  import fetchie_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_t        dbg_state
);

  // Handshake: a requester holds req (and its payload) until it sees a
  // one-cycle ack; the arbiter holds mem_req/payload until a one-cycle mem_ack.
  arb_state_t        r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;
  logic              w_pick_d;

`ifdef ARB_RR_EN
  // Set when the most recent grant went to fetch; data wins the next tie.
  logic r_last_f;

  assign w_pick_d = d_req & (~f_req | r_last_f);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_f <= 1'b1;
    end else if (r_state == IDLE && (f_req || d_req)) begin
      r_last_f <= ~w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= GRANT_D;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
          end else if (f_req) begin
            r_state     <= GRANT_F;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= f_addr;
            r_mem_wdata <= '0;
          end
        end
        GRANT_F, GRANT_D: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Acks are gated by the live grant so an ack while idle is dropped.
  assign f_ack     = mem_ack & (r_state == GRANT_F);
  assign d_ack     = mem_ack & (r_state == GRANT_D);
  assign f_data    = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Define ARB_RR_EN to match the DUT build.
module tb_mem_arbiter;
  import fetchie_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  arb_state_t    dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the memory port and what it asked for
  int            m_grant;
  bit            m_last_f;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;

  logic [AW-1:0]   f_exp_q[$];
  logic [AW+DW:0]  d_exp_q[$];
  byte             grant_log[$];

  bit            f_ack_seen, d_ack_seen, hold_f, hold_d, rand_en, fixed_en;
  int            mem_delay, wait_cnt;
  logic [DW-1:0] fixed_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  task automatic issue_f(input logic [AW-1:0] addr);
    f_req  = 1'b1;
    f_addr = addr;
    f_exp_q.push_back(addr);
  endtask

  task automatic issue_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = we ? wdata : '0;
    d_exp_q.push_back({we, addr, (we ? wdata : {DW{1'b0}})});
  endtask

  task automatic assert_reset();
    reset    = 1'b0;
    m_grant  = 0;
    m_last_f = 1'b1;
    wait_cnt = -1;
  endtask

  // Called at the rising edge with the inputs the DUT just sampled.
  task automatic model_step();
    bit pick_d;
    if (m_grant != 0) begin
      if (mem_ack) m_grant = 0;
    end else if (f_req || d_req) begin
`ifdef ARB_RR_EN
      pick_d = d_req && (!f_req || m_last_f);
`else
      pick_d = d_req;
`endif
      if (pick_d) begin
        m_grant = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_last_f = 1'b0;
      end else begin
        m_grant = 1; m_addr = f_addr; m_we = 1'b0; m_wdata = '0; m_last_f = 1'b1;
      end
    end
  endtask

  task automatic drive_stim();
    mem_ack = 1'b0;
    if (f_ack_seen) begin
      f_ack_seen = 1'b0;
      if (hold_f) issue_f(f_addr);
      else f_req = 1'b0;
    end
    if (d_ack_seen) begin
      d_ack_seen = 1'b0;
      if (hold_d) issue_d(d_we, d_addr, d_wdata);
      else d_req = 1'b0;
    end
    if (rand_en) begin
      if (!f_req && $urandom_range(0, 2) == 0) issue_f($urandom);
      if (!d_req && $urandom_range(0, 2) == 0) issue_d(1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    if (mem_req && reset) begin
      if (wait_cnt < 0) wait_cnt = (mem_delay < 0) ? $urandom_range(0, 3) : mem_delay;
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = fixed_en ? fixed_rdata : $urandom;
        wait_cnt  = -1;
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = -1;
      if (rand_en && $urandom_range(0, 9) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  endtask

  task automatic compare();
    chk("mem_req", mem_req, m_grant != 0);
    chk("busy", busy, m_grant != 0);
    chk("f_ack", f_ack, mem_ack && m_grant == 1);
    chk("d_ack", d_ack, mem_ack && m_grant == 2);
    if (m_grant != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (f_ack) begin
      f_ack_seen = 1'b1;
      grant_log.push_back(8'h46);
      chk("f_data", f_data, mem_rdata);
      if (f_exp_q.size() == 0) fail_msg("f_ack_spurious");
      else chk("f_txn_addr", mem_addr, f_exp_q.pop_front());
    end
    if (d_ack) begin
      d_ack_seen = 1'b1;
      grant_log.push_back(8'h44);
      chk("d_rdata", d_rdata, mem_rdata);
      if (d_exp_q.size() == 0) fail_msg("d_ack_spurious");
      else chk("d_txn", {mem_we, mem_addr, mem_wdata}, d_exp_q.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    #1;
    drive_stim();
    @(negedge clk);
    compare();
  endtask

  initial begin
    bit    got, first;
    int    n;
    string exp_s;

    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    f_ack_seen = 0; d_ack_seen = 0; hold_f = 0; hold_d = 0; rand_en = 0; fixed_en = 0;
    mem_delay = 1; fixed_rdata = '0; m_addr = '0; m_we = 0; m_wdata = '0;
    assert_reset();
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    cycle();
    cycle();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    cycle();

    // single fetch, memory answers 3 cycles after mem_req
    mem_delay = 3; fixed_en = 1; fixed_rdata = 32'hDEADBEEF;
    issue_f(32'h100);
    got = 0; n = 0; first = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (mem_req) begin
        n++;
        if (first) begin
          chk("fetch_mem_addr", mem_addr, 32'h100);
          chk("fetch_mem_we", mem_we, 0);
          first = 0;
        end
      end
      if (f_ack) begin
        got = 1;
        chk("fetch_f_data", f_data, 32'hDEADBEEF);
        chk("fetch_d_ack", d_ack, 0);
        chk("fetch_req_cycles", n, 4);
      end
    end
    if (!got) fail_msg("fetch_ack_timeout");
    cycle();
    chk("fetch_ack_pulse", f_ack, 0);
    chk("fetch_idle", dbg_state, IDLE);

    // single store
    mem_delay = 2; fixed_en = 0;
    issue_d(1'b1, 32'h2000, 32'h12345678);
    got = 0; first = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (mem_req && first) begin
        chk("store_mem_we", mem_we, 1);
        chk("store_mem_addr", mem_addr, 32'h2000);
        chk("store_mem_wdata", mem_wdata, 32'h12345678);
        first = 0;
      end
      if (d_ack) begin
        got = 1;
        chk("store_f_ack", f_ack, 0);
      end
    end
    if (!got) fail_msg("store_ack_timeout");
    cycle();
    chk("store_idle", dbg_state, IDLE);
    chk("store_busy", busy, 0);

    // both requesters held: grant order after a fresh reset
    assert_reset();
    cycle();
    reset = 1'b1;
    grant_log.delete();
    hold_f = 1; hold_d = 1; mem_delay = 1;
    issue_f(32'h400);
    issue_d(1'b0, 32'h500, '0);
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) cycle();
`ifdef ARB_RR_EN
    exp_s = "DFDF";
`else
    exp_s = "DDDD";
`endif
    if (grant_log.size() < 4) fail_msg("order_timeout");
    else for (int i = 0; i < 4; i++) chk($sformatf("order_%0d", i), grant_log[i], exp_s[i]);
    hold_f = 0; hold_d = 0;
    for (int i = 0; i < 60 && (f_exp_q.size() != 0 || d_exp_q.size() != 0 || mem_req); i++) cycle();
    if (f_exp_q.size() != 0 || d_exp_q.size() != 0) fail_msg("order_drain_timeout");

    // reset while the data grant is outstanding
    mem_delay = 8;
    issue_d(1'b0, 32'h3000, '0);
    for (int i = 0; i < 10 && !mem_req; i++) cycle();
    if (!mem_req) fail_msg("abort_grant_timeout");
    cycle();
    mem_ack = 1'b1;
    assert_reset();
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_d_ack", d_ack, 0);
    chk("abort_state", dbg_state, IDLE);
    cycle();
    reset = 1'b1;
    mem_delay = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (d_ack) got = 1;
    end
    if (!got) fail_msg("abort_regrant_timeout");
    cycle();

    // stray mem_ack while idle
    mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    chk("stray_f_ack", f_ack, 0);
    chk("stray_d_ack", d_ack, 0);
    cycle();
    chk("stray_state", dbg_state, IDLE);
    chk("stray_busy", busy, 0);

    // randomized traffic with random memory latency and stray acks
    rand_en = 1; mem_delay = -1;
    for (int i = 0; i < 3000; i++) cycle();
    rand_en = 0;
    for (int i = 0; i < 100 && (f_req || d_req || mem_req); i++) cycle();
    if (f_req || d_req || mem_req) fail_msg("random_drain_timeout");
    chk("final_f_queue", f_exp_q.size(), 0);
    chk("final_d_queue", d_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port f_req  in  1  fetch read request; held until f_ack.
REQ-006 SHALL have port f_addr  in  ADDR_W  fetch address; stable while f_req.
REQ-007 SHALL have port f_ack  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port f_data  out  DATA_W  fetch read data; valid with f_ack.
REQ-009 SHALL have port d_req  in  1  load/store request; held until d_ack.
REQ-010 SHALL have port d_we  in  1  1=store, 0=load; stable while d_req.
REQ-011 SHALL have port d_addr  in  ADDR_W  load/store address.
REQ-012 SHALL have port d_wdata  in  DATA_W  store data.
REQ-013 SHALL have port d_ack  out  1  one-cycle load/store completion pulse.
REQ-014 SHALL have port d_rdata  out  DATA_W  load data; valid with d_ack.
REQ-015 SHALL have port mem_req  out  1  memory request; held until mem_ack.
REQ-016 SHALL have port mem_we  out  1  memory write enable.
REQ-017 SHALL have port mem_addr  out  ADDR_W  memory address.
REQ-018 SHALL have port mem_wdata  out  DATA_W  memory write data.
REQ-019 SHALL have port mem_ack  in  1  memory completion pulse; mem_rdata valid same cycle.
REQ-020 SHALL have port mem_rdata  in  DATA_W  memory read data.
REQ-021 SHALL have port busy  out  1  high in any GRANT state.

Function
REQ-022 SHALL implement FSM states IDLE, GRANT_F, GRANT_D.
REQ-023 IDLE SHALL sample f_req/d_req each cycle and move to the winning GRANT state on the next edge; mem_req stays 0 in IDLE.
REQ-024 In GRANT_x, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from registers captured on IDLE exit (fetch: mem_we=0, mem_wdata=0).
REQ-025 f_ack/d_ack SHALL equal mem_ack gated by the current grant (combinational); f_data/d_rdata SHALL pass mem_rdata through.
REQ-026 On mem_ack the FSM SHALL return to IDLE; minimum request-to-ack latency is 2 cycles; back-to-back grants are separated by one IDLE cycle.
REQ-027 The non-granted ack SHALL remain 0; a request arriving during a grant SHALL wait, not be dropped.
REQ-028 A mem_ack in IDLE SHALL be ignored; neither ack asserts.
REQ-029 Requests SHALL NOT be aborted; deassertion of f_req/d_req mid-grant does not cancel mem_req (requester contract violation, undefined result data).

Reset
REQ-030 On reset low, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, f_ack=0, d_ack=0, RR pointer=fetch-last, immediately and independent of clk.
REQ-031 Reset mid-grant SHALL drop mem_req at once; no ack is generated for the aborted transfer.

Configuration
REQ-032 With ARB_RR_EN defined, simultaneous requests SHALL alternate: the requester not granted last wins; pointer updates on each grant.
REQ-033 Without ARB_RR_EN, simultaneous requests SHALL always grant d_req (fixed data priority); no pointer register exists.

Structure
REQ-034 Package fetchie_pkg SHALL hold arb_state_t (IDLE, GRANT_F, GRANT_D) and default ADDR_W/DATA_W constants.
REQ-035 No sub-module; single module with FSM plus request-capture registers.

Verification
REQ-036 Reset, f_req=1 f_addr=0x100, mem_ack 3 cycles after mem_req -> mem_addr=0x100, mem_we=0, f_ack pulses 1 cycle with f_data=mem_rdata=0xDEADBEEF, d_ack=0.
REQ-037 d_req=1 d_we=1 d_addr=0x2000 d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678, d_ack on mem_ack, state IDLE next cycle.
REQ-038 f_req and d_req both held, mem_ack 1 cycle after each mem_req -> without ARB_RR_EN: D,D,D...; with ARB_RR_EN: D,F,D,F grant order (pointer fetch-last after reset).
REQ-039 Drive reset low while GRANT_D with mem_req=1 -> mem_req=0 and busy=0 same cycle, no d_ack; after release, held d_req re-granted.
REQ-040 Pulse mem_ack while IDLE and no requests -> f_ack=0, d_ack=0, state remains IDLE.
